// File: rtl/dram_arbiter.sv
// Two-requester (CPU load/store, video fetch) arbiter for the data-RAM port a.
// Optional DRAM_ARB_RR_EN replaces CPU priority + starvation guard with round-robin.
module dram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic {OWN_CPU = 1'b0, OWN_VID = 1'b1} owner_t;

    logic   vid_wins;
    logic   tag1_vld, tag2_vld;
    owner_t tag1_own, tag2_own;
    logic   resp;

`ifdef DRAM_ARB_RR_EN
    owner_t last_gnt;

    assign vid_wins = (last_gnt == OWN_CPU);

    // Starts at VID so the CPU wins the first contention after reset.
    always_ff @(posedge clk) begin
        if (rst)          last_gnt <= OWN_VID;
        else if (cpu_gnt) last_gnt <= OWN_CPU;
        else if (vid_gnt) last_gnt <= OWN_VID;
    end
`else
    logic [7:0] wait_cnt;

    assign vid_wins = (wait_cnt == 8'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (vid_gnt)
            wait_cnt <= '0;
        else if (vid_req && !vid_wins)
            wait_cnt <= wait_cnt + 8'd1;
    end
`endif

    // Grants are combinational; reset masks both so nothing is accepted in a reset cycle.
    assign cpu_gnt = !rst && cpu_req && !(vid_req && vid_wins);
    assign vid_gnt = !rst && vid_req && !(cpu_req && !vid_wins);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            tag1_vld  <= 1'b0;
            tag1_own  <= OWN_CPU;
            tag2_vld  <= 1'b0;
            tag2_own  <= OWN_CPU;
        end else begin
            mem_wren <= cpu_gnt && cpu_we;
            if (cpu_gnt) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (vid_gnt) begin
                mem_addr  <= vid_addr;
            end
            // Only reads get a tag; writes complete silently.
            tag1_vld <= (cpu_gnt && !cpu_we) || vid_gnt;
            tag1_own <= vid_gnt ? OWN_VID : OWN_CPU;
            tag2_vld <= tag1_vld;
            tag2_own <= tag1_own;
        end
    end

    // Response stage lines up with mem_q; rst kills a tag already in its last stage.
    assign resp       = tag2_vld && !rst;
    assign cpu_rvalid = resp && (tag2_own == OWN_CPU);
    assign vid_rvalid = resp && (tag2_own == OWN_VID);
    assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
    assign vid_rdata  = vid_rvalid ? mem_q : '0;

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single data-RAM port (port a of the data memory) between two requesters:
  - the ARM core's load/store path (CPU);
  - a video fetch engine that reads display data for the video generator (VID).
- Pipelined req/gnt acceptance, fixed CPU priority with a starvation guard for VID.
- Read data is returned on a per-requester rvalid pulse that tracks the RAM's registered-read latency.
- Sits between the requesters and the dram instance, all in the clk domain.

Parameters:
- ADDR_W, 10, word address width to RAM.
- DATA_W, 32, data width.
- MAX_WAIT, 8, cycles a pending VID request may be denied before it overrides CPU priority (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- vid_req  in  1  video read request (read-only)
- vid_addr  in  ADDR_W  video word address
- vid_gnt  out  1  video request accepted this cycle
- vid_rvalid  out  1  video read data valid
- vid_rdata  out  DATA_W  video read data
- mem_addr  out  ADDR_W  to RAM address_a
- mem_wdata  out  DATA_W  to RAM data_a
- mem_wren  out  1  to RAM wren_a
- mem_q  in  DATA_W  from RAM q_a (valid 1 cycle after address registered)

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: all outputs 0, wait counter 0, tag pipeline cleared.
- Handshake:
  - A request is accepted in cycle N when req=1 and gnt=1. gnt is combinational from req and arbiter state.
  - Requester holds addr/we/wdata stable while req=1 and gnt=0.
  - After gnt it may present a new request the next cycle; back-to-back accepts are allowed.
- Arbitration, per cycle:
  - If only one requester has req=1, it is granted.
  - If both have req=1: VID is granted when wait_cnt == MAX_WAIT, otherwise CPU is granted.
  - Never both gnt in one cycle.
- Starvation counter (wait_cnt, 8 bit):
  - +1 in each cycle with vid_req=1 and vid_gnt=0, saturating at MAX_WAIT.
  - Cleared to 0 on vid_gnt.
  - Holds when vid_req=0.
- Issue stage (registered):
  - At the edge ending cycle N, mem_addr and mem_wdata load from the granted requester.
  - mem_wren = 1 only for a granted CPU write.
  - With no grant, mem_wren = 0 and mem_addr holds its last value.
- Tag pipeline: 2-stage tag {valid, owner} for reads only; writes produce no response.
- Read latency: accept in cycle N → mem_addr driven in N+1 → mem_q valid in N+2.
  - In N+2, the owner's rvalid = 1 (one-cycle pulse).
  - The owner's rdata = mem_q; rdata is registered-through, so it is combinational from mem_q gated by the tag.
  - The non-owner's rvalid = 0.
- Ordering: responses return in acceptance order; at most one rvalid per cycle overall.
- Write-then-read of the same address in consecutive accepts returns the new data (RAM write precedes the following read).
- Reset mid-operation: in-flight tags are discarded; no rvalid is produced for any request accepted before or during the reset cycle; mem_wren = 0 from the cycle after rst is sampled.
- Unused combinations:
  - cpu_we while cpu_req=0 is ignored.
  - vid_req during rst is ignored (gnt forced 0 while rst=1).

Optional Feature:
- Macro: DRAM_ARB_RR_EN.
- Defined:
  - Arbitration is round-robin. A 1-bit last-grant pointer is reset to VID so CPU wins the first contention.
  - On contention the requester not last granted wins.
  - wait_cnt and MAX_WAIT are unused; wait_cnt is not synthesized.
- Undefined: fixed CPU priority with starvation guard as above.

Test Plan:
- CPU read alone: RAM[0x004]=0xDEADBEEF, cpu_req/cpu_we=0/addr=0x004 in cycle 0 → cpu_gnt=1 in cycle 0; mem_addr=0x004 in cycle 1; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in cycle 2 only; vid_rvalid stays 0.
- CPU write then read: write 0x12345678 to 0x010 in cycle 0, read 0x010 in cycle 1 → mem_wren=1 only in cycle 1; cpu_rvalid in cycle 3 with 0x12345678.
- Contention: cpu_req and vid_req both high in cycle 0, CPU drops in cycle 1 → cpu_gnt in cycle 0, vid_gnt in cycle 1; cpu_rvalid in cycle 2, vid_rvalid in cycle 3.
- Starvation, MAX_WAIT=8: cpu_req and vid_req held high from cycle 0 → cpu_gnt in cycles 0–7; vid_gnt=1 and cpu_gnt=0 in cycle 8; cpu_gnt again in cycles 9–16; vid_gnt again in cycle 17.
- Reset mid-flight: VID reads accepted in cycles 0 and 1, rst=1 in cycle 2 → no vid_rvalid in cycles 2–4; all outputs 0 in cycle 3.
- DRAM_ARB_RR_EN defined, both requesters continuously high from cycle 0 → grants alternate CPU, VID, CPU, VID… starting with CPU in cycle 0.
